sdram_init_seq: RTL and testbench

//  Power-up sequencer directly downstream of the SDRAM PLL. Runs on the PLL's 100 MHz outclk_0, qualifies its

---
 rtl/sdram_pkg.sv | 54 +++++
 rtl/sync_2ff.sv | 24 ++
 rtl/sdram_init_seq.sv | 198 +++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer state set and
// mode register field helpers. The SDRAM controller imports this package too.
package sdram_pkg;

   localparam int SDR_ADDR_W = 13;
   localparam int SDR_BA_W   = 2;
   localparam int SDR_CMD_W  = 4;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [SDR_CMD_W-1:0] CMD_INHIBIT   = 4'b1111;
   localparam logic [SDR_CMD_W-1:0] CMD_NOP       = 4'b0111;
   localparam logic [SDR_CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [SDR_CMD_W-1:0] CMD_REFRESH   = 4'b0001;
   localparam logic [SDR_CMD_W-1:0] CMD_LOAD_MODE = 4'b0000;

   // A10 high during PRECHARGE selects all banks
   localparam logic [SDR_ADDR_W-1:0] ADDR_PRECHARGE_ALL = 13'h0400;

   typedef enum logic [3:0] {
      ST_WAIT_LOCK,
      ST_POWERUP,
      ST_PRECHARGE,
      ST_WAIT_TRP,
      ST_REFRESH,
      ST_WAIT_TRFC,
      ST_LOAD_MODE,
      ST_WAIT_TMRD,
      ST_DONE
   } init_state_e;

   // Mode register layout: [2:0] burst length, [3] burst type,
   // [6:4] CAS latency, [8:7] operating mode, [9] write burst mode.
   function automatic logic [SDR_ADDR_W-1:0] mode_reg_make(
      input logic [2:0] cas_lat,
      input logic       burst_type,
      input logic [2:0] burst_len_code,
      input logic       write_single
   );
      return {3'b000, write_single, 2'b00, cas_lat, burst_type, burst_len_code};
   endfunction

   function automatic logic [2:0] mode_cas_lat(input logic [SDR_ADDR_W-1:0] mode);
      return mode[6:4];
   endfunction

   function automatic logic [2:0] mode_burst_len_code(input logic [SDR_ADDR_W-1:0] mode);
      return mode[2:0];
   endfunction

   function automatic logic mode_burst_interleaved(input logic [SDR_ADDR_W-1:0] mode);
      return mode[3];
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single level signal crossing into clk_i.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: qualifies PLL lock, then issues NOP wait, PRECHARGE ALL,
// N x AUTO REFRESH and LOAD MODE, holding the controller in reset until complete.
//
// state         | meaning
// --------------+--------------------------------------------------------
// ST_WAIT_LOCK  | CKE low, INHIBIT; counting consecutive synced-lock cycles
// ST_POWERUP    | CKE high, NOP for the power-up interval
// ST_PRECHARGE  | single PRECHARGE ALL cycle
// ST_WAIT_TRP   | NOPs for tRP
// ST_REFRESH    | single AUTO REFRESH cycle, refresh count advances
// ST_WAIT_TRFC  | NOPs for tRFC, then next refresh or mode load
// ST_LOAD_MODE  | single LOAD MODE cycle with MODE_REG on the address bus
// ST_WAIT_TMRD  | NOPs for tMRD
// ST_DONE       | init_done high, NOP, controller released
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int              CLK_FREQ_MHZ = 100,
   parameter int              T_POWERUP_US = 200,
   parameter int              LOCK_FILTER  = 16,
   parameter int              TRP_CYC      = 2,
   parameter int              TRFC_CYC     = 7,
   parameter int              TMRD_CYC     = 2,
   parameter int              N_REFRESH    = 8,
   parameter logic [12:0]     MODE_REG     = 13'h030
) (
   input  logic        refclk,
   input  logic        rst,
   input  logic        pll_locked,
   output logic        sdr_cke,
   output logic [3:0]  sdr_cmd,
   output logic [12:0] sdr_addr,
   output logic [1:0]  sdr_ba,
   output logic        init_done,
   output logic        ctrl_rst
);

   localparam int PWR_CYC = CLK_FREQ_MHZ * T_POWERUP_US;
   localparam int WAIT_W  = (PWR_CYC < 1) ? 1 : $clog2(PWR_CYC + 1);
   localparam int REF_W   = (N_REFRESH < 1) ? 1 : $clog2(N_REFRESH + 1);
   localparam int FILT_N  = (LOCK_FILTER < 1) ? 1 : LOCK_FILTER;
   localparam int FILT_W  = $clog2(FILT_N + 1);

   localparam logic [WAIT_W-1:0] PWR_LOAD  = WAIT_W'((PWR_CYC  > 0) ? PWR_CYC  - 1 : 0);
   localparam logic [WAIT_W-1:0] TRP_LOAD  = WAIT_W'((TRP_CYC  > 0) ? TRP_CYC  - 1 : 0);
   localparam logic [WAIT_W-1:0] TRFC_LOAD = WAIT_W'((TRFC_CYC > 0) ? TRFC_CYC - 1 : 0);
   localparam logic [WAIT_W-1:0] TMRD_LOAD = WAIT_W'((TMRD_CYC > 0) ? TMRD_CYC - 1 : 0);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_N - 1);
   localparam logic [REF_W-1:0]  REF_TOTAL = REF_W'(N_REFRESH);

   // with zero refreshes configured the sequence goes straight to the mode load
   localparam init_state_e AFTER_TRP = (N_REFRESH == 0) ? ST_LOAD_MODE : ST_REFRESH;

   logic lock_s;

   init_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic [REF_W-1:0]  ref_q,   ref_d;
   logic [FILT_W-1:0] filt_q,  filt_d;
   logic [REF_W-1:0]  ref_inc;

   logic        cke_q,   cke_d;
   logic [3:0]  cmd_q,   cmd_d;
   logic [12:0] addr_q,  addr_d;
   logic [1:0]  ba_q,    ba_d;
   logic        done_q,  done_d;
   logic        crst_q;

   sync_2ff u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (pll_locked),
      .q_o   (lock_s)
   );

   assign ref_inc = ref_q + REF_W'(1);

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= ST_WAIT_LOCK;
         wait_q  <= '0;
         ref_q   <= '0;
         filt_q  <= '0;
         cke_q   <= 1'b0;
         cmd_q   <= CMD_INHIBIT;
         addr_q  <= '0;
         ba_q    <= '0;
         done_q  <= 1'b0;
         crst_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         ref_q   <= ref_d;
         filt_q  <= filt_d;
         cke_q   <= cke_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
         done_q  <= done_d;
         crst_q  <= ~done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ref_d   = ref_q;
      filt_d  = filt_q;

      if (!lock_s) begin
         // lock loss wins over any transition due this cycle
         state_d = ST_WAIT_LOCK;
         wait_d  = '0;
         ref_d   = '0;
         filt_d  = '0;
      end else begin
         unique case (state_q)
            ST_WAIT_LOCK: begin
               if (filt_q == FILT_LAST) begin
                  filt_d  = '0;
                  wait_d  = PWR_LOAD;
                  state_d = (PWR_CYC == 0) ? ST_PRECHARGE : ST_POWERUP;
               end else begin
                  filt_d = filt_q + FILT_W'(1);
               end
            end
            ST_POWERUP: begin
               if (wait_q == '0) state_d = ST_PRECHARGE;
               else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_PRECHARGE: begin
               wait_d  = TRP_LOAD;
               state_d = (TRP_CYC == 0) ? AFTER_TRP : ST_WAIT_TRP;
            end
            ST_WAIT_TRP: begin
               if (wait_q == '0) state_d = AFTER_TRP;
               else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_REFRESH: begin
               ref_d  = ref_inc;
               wait_d = TRFC_LOAD;
               if (TRFC_CYC != 0)          state_d = ST_WAIT_TRFC;
               else if (ref_inc < REF_TOTAL) state_d = ST_REFRESH;
               else                          state_d = ST_LOAD_MODE;
            end
            ST_WAIT_TRFC: begin
               if (wait_q != '0)           wait_d  = wait_q - WAIT_W'(1);
               else if (ref_q < REF_TOTAL) state_d = ST_REFRESH;
               else                        state_d = ST_LOAD_MODE;
            end
            ST_LOAD_MODE: begin
               wait_d  = TMRD_LOAD;
               state_d = (TMRD_CYC == 0) ? ST_DONE : ST_WAIT_TMRD;
            end
            ST_WAIT_TMRD: begin
               if (wait_q == '0) state_d = ST_DONE;
               else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_WAIT_LOCK;
         endcase
      end
   end

   // outputs are decoded from the next state so the pins change on the same edge as the state
   always_comb begin
      cke_d  = 1'b1;
      cmd_d  = CMD_NOP;
      addr_d = '0;
      ba_d   = '0;
      done_d = 1'b0;
      unique case (state_d)
         ST_WAIT_LOCK: begin
            cke_d = 1'b0;
            cmd_d = CMD_INHIBIT;
         end
         ST_PRECHARGE: begin
            cmd_d  = CMD_PRECHARGE;
            addr_d = ADDR_PRECHARGE_ALL;
         end
         ST_REFRESH:   cmd_d = CMD_REFRESH;
         ST_LOAD_MODE: begin
            cmd_d  = CMD_LOAD_MODE;
            addr_d = MODE_REG;
         end
         ST_DONE:      done_d = 1'b1;
         default:      cmd_d = CMD_NOP;
      endcase
   end

   assign sdr_cke   = cke_q;
   assign sdr_cmd   = cmd_q;
   assign sdr_addr  = addr_q;
   assign sdr_ba    = ba_q;
   assign init_done = done_q;
   assign ctrl_rst  = crst_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: stimulus schedules expected command events
// from the sequence timing rules; a negedge monitor matches what the pins show.
module tb_sdram_init_seq;
   import sdram_pkg::*;

   localparam int          LOCK_FILTER = 16;
   localparam int          SYNC_LAT    = 2;
   localparam int          PWR         = 100;
   localparam int          TRP         = 2;
   localparam int          TRFC        = 7;
   localparam int          TMRD        = 2;
   localparam int          NREF        = 8;
   localparam logic [12:0] MODE        = 13'h030;
   localparam int          SEQ_LEN     = SYNC_LAT + LOCK_FILTER + PWR + (TRP + 1)
                                         + NREF * (TRFC + 1) + (TMRD + 1);

   logic        refclk = 1'b0;
   logic        rst = 1'b1;
   logic        pll_locked = 1'b0;
   logic        sdr_cke;
   logic [3:0]  sdr_cmd;
   logic [12:0] sdr_addr;
   logic [1:0]  sdr_ba;
   logic        init_done;
   logic        ctrl_rst;

   sdram_init_seq #(.T_POWERUP_US(1)) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .sdr_cke    (sdr_cke),
      .sdr_cmd    (sdr_cmd),
      .sdr_addr   (sdr_addr),
      .sdr_ba     (sdr_ba),
      .init_done  (init_done),
      .ctrl_rst   (ctrl_rst)
   );

   always #5 refclk = ~refclk;

   int cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   typedef enum int {EV_CKE_UP, EV_PRE, EV_REF, EV_LMR, EV_DONE, EV_LOST} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       at;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cke_up_at = -1;
   int  rise_at = 0;
   bit  mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: a lock that starts being seen at cycle r yields the whole
   // command timeline from the spacing rules.
   task automatic sched_rise(input int r);
      int t;
      rise_at   = r;
      t         = r + SYNC_LAT + LOCK_FILTER;
      cke_up_at = t;
      exp_q.push_back('{EV_CKE_UP, t});
      t += PWR;
      exp_q.push_back('{EV_PRE, t});
      t += TRP + 1;
      for (int i = 0; i < NREF; i++) begin
         exp_q.push_back('{EV_REF, t});
         t += TRFC + 1;
      end
      exp_q.push_back('{EV_LMR, t});
      t += TMRD + 1;
      exp_q.push_back('{EV_DONE, t});
   endtask

   // Sequence abort taking effect on cycle l: everything from l on is cancelled.
   task automatic model_loss(input int l);
      ev_t keep[$];
      foreach (exp_q[i]) if (exp_q[i].at < l) keep.push_back(exp_q[i]);
      exp_q = keep;
      if (cke_up_at >= 0 && cke_up_at < l) exp_q.push_back('{EV_LOST, l});
      cke_up_at = -1;
   endtask

   task automatic lock_set(input logic v);
      pll_locked = v;
      if (v) sched_rise(cyc);
      else   model_loss(cyc + SYNC_LAT + 1);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      model_loss(cyc + 1);
      @(negedge refclk);
      rst = 1'b0;
      if (pll_locked) sched_rise(cyc);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge refclk);
   endtask

   // ---------------- monitor ----------------
   logic prev_cke;
   logic prev_done;
   int   last_cmd_at = -1000;
   int   last_wait = 0;
   int   ref_seen = 0;

   task automatic handle(input ev_kind_e k);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", int'(k), cyc);
         return;
      end
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_cycle", cyc, e.at);
      case (k)
         EV_CKE_UP: begin
            ref_seen = 0;
            chk("cke_up_cmd", sdr_cmd, CMD_NOP);
         end
         EV_PRE: chk("pre_a10", sdr_addr[10], 1);
         EV_REF: ref_seen++;
         EV_LMR: begin
            chk("lmr_addr", sdr_addr, MODE);
            chk("lmr_ba", sdr_ba, 0);
         end
         EV_DONE: begin
            chk("done_ref_count", ref_seen, NREF);
            chk("done_cmd", sdr_cmd, CMD_NOP);
            chk("done_cke", sdr_cke, 1);
         end
         EV_LOST: begin
            chk("lost_cmd", sdr_cmd, CMD_INHIBIT);
            chk("lost_done", init_done, 0);
            chk("lost_ctrl_rst", ctrl_rst, 1);
         end
         default: ;
      endcase
   endtask

   always @(negedge refclk) begin
      if (mon_en) begin
         chk("ctrl_rst_vs_done", ctrl_rst, !init_done);
         if (!sdr_cke && prev_cke) begin
            handle(EV_LOST);
            last_cmd_at = -1000;
         end
         if (sdr_cke && !prev_cke) handle(EV_CKE_UP);
         if (sdr_cmd == CMD_PRECHARGE || sdr_cmd == CMD_REFRESH || sdr_cmd == CMD_LOAD_MODE) begin
            chk("cmd_spacing", (cyc - last_cmd_at) > last_wait, 1);
            last_cmd_at = cyc;
            if (sdr_cmd == CMD_PRECHARGE) begin
               last_wait = TRP;
               handle(EV_PRE);
            end else if (sdr_cmd == CMD_REFRESH) begin
               last_wait = TRFC;
               handle(EV_REF);
            end else begin
               last_wait = TMRD;
               handle(EV_LMR);
            end
         end else if (sdr_cmd != CMD_NOP && sdr_cmd != CMD_INHIBIT) begin
            chk("cmd_legal", sdr_cmd, CMD_NOP);
         end
         if (init_done && !prev_done) handle(EV_DONE);
         prev_cke  = sdr_cke;
         prev_done = init_done;
      end
   end

   always @(posedge refclk) begin
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d, limit 20000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int off;
      int mode;

      rst        = 1'b1;
      pll_locked = 1'b0;
      repeat (4) begin
         @(negedge refclk);
         chk("rst_cmd", sdr_cmd, CMD_INHIBIT);
         chk("rst_cke", sdr_cke, 0);
         chk("rst_ctrl_rst", ctrl_rst, 1);
         chk("rst_done", init_done, 0);
         chk("rst_addr", sdr_addr, 0);
         chk("rst_ba", sdr_ba, 0);
      end
      rst       = 1'b0;
      prev_cke  = sdr_cke;
      prev_done = init_done;
      mon_en    = 1'b1;
      repeat (3) @(negedge refclk);
      chk("idle_unlocked_cmd", sdr_cmd, CMD_INHIBIT);

      // steady lock: full sequence
      lock_set(1'b1);
      wait_cyc(rise_at + SEQ_LEN + 5);
      chk("seq1_done_level", init_done, 1);

      // glitch at filter count 10 restarts qualification
      lock_set(1'b0);
      repeat (6) @(negedge refclk);
      lock_set(1'b1);
      wait_cyc(rise_at + 10);
      lock_set(1'b0);
      @(negedge refclk);
      lock_set(1'b1);
      wait_cyc(rise_at + SEQ_LEN + 5);
      chk("glitch_done_level", init_done, 1);

      // lock lost during the 4th refresh wait
      lock_set(1'b0);
      repeat (5) @(negedge refclk);
      lock_set(1'b1);
      wait_cyc(rise_at + SYNC_LAT + LOCK_FILTER + PWR + TRP + 1 + 3 * (TRFC + 1)
               + int'($urandom_range(1, 4)));
      lock_set(1'b0);
      repeat (6) @(negedge refclk);
      chk("loss_inhibit", sdr_cmd, CMD_INHIBIT);
      lock_set(1'b1);
      wait_cyc(rise_at + SEQ_LEN + 5);
      chk("relock_done_level", init_done, 1);

      // single-cycle rst after completion
      rst_pulse();
      chk("rstpulse_done", init_done, 0);
      chk("rstpulse_ctrl_rst", ctrl_rst, 1);
      wait_cyc(rise_at + SEQ_LEN + 5);
      chk("rstpulse_redone", init_done, 1);

      // randomised aborts at arbitrary points of the sequence
      for (int k = 0; k < 6; k++) begin
         lock_set(1'b0);
         repeat (3 + $urandom_range(0, 5)) @(negedge refclk);
         lock_set(1'b1);
         off  = int'($urandom_range(1, SEQ_LEN - 1));
         mode = int'($urandom_range(0, 2));
         wait_cyc(rise_at + off);
         if (mode == 0) begin
            lock_set(1'b0);
            repeat ($urandom_range(1, 6)) @(negedge refclk);
            lock_set(1'b1);
         end else if (mode == 1) begin
            rst_pulse();
         end else begin
            lock_set(1'b0);
            @(negedge refclk);
            lock_set(1'b1);
         end
         wait_cyc(rise_at + SEQ_LEN + 5);
         chk("rand_done_level", init_done, 1);
      end

      chk("pending_events", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
